// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-lab types and constants
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } add_state_t;

  localparam int DEFAULT_ADD_WIDTH = 8;

endpackage

// File: rtl/full_add_1bit.sv
// rtl/full_add_1bit.sv - gate-level 1-bit full adder cell
module full_add_1bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign s       = x_xor_y ^ cin;
  assign cout    = (x & y) | (cin & x_xor_y);

endmodule

// File: rtl/serial_adder_nbit.sv
// rtl/serial_adder_nbit.sv - bit-serial N-bit adder, LSB first, one bit per clock
module serial_adder_nbit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  add_state_t       state;
  add_state_t       state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_add_1bit u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign sum_sh_next = {fa_s, sum_sh[WIDTH-1:1]};
  assign last_bit    = (cnt == LAST_BIT);
  assign busy        = (state == SHIFT);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sum/cout only update on the edge entering DONE, so partial sums stay hidden
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        SHIFT: begin
          sum_sh <= sum_sh_next;
          carry  <= fa_c;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= sum_sh_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb/tb_serial_adder_nbit.sv - directed-vector bench for serial_adder_nbit
module tb_serial_adder_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic fa_x = 1'b0, fa_y = 1'b0, fa_ci = 1'b0;
  logic fa_s, fa_co;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  full_add_1bit u_fa (
    .x    (fa_x),
    .y    (fa_y),
    .cin  (fa_ci),
    .s    (fa_s),
    .cout (fa_co)
  );

  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // returns the negedge index (1-based) where done is seen, or -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum got %h want 00", sum); end
    if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout got %b want 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int done_cyc;
    launch(8'h35, 8'h4A, 1'b0);
    done_cyc = -1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      vectors += 2;
      if (i <= 8) begin
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy cyc %0d got %b want 1", i, busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done cyc %0d got %b want 0", i, done); end
      end else begin
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy cyc %0d got %b want 0", i, busy); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done cyc %0d got %b want 1", i, done); end
      end
      if (i == 5) begin
        vectors++;
        if (sum !== 8'h00) begin miscompares++; $display("FAIL basic_hidden_partial got %h want 00", sum); end
      end
    end
    vectors += 3;
    if (sum !== 8'h7F) begin miscompares++; $display("FAIL basic_sum got %h want 7f", sum); end
    if (cout !== 1'b0) begin miscompares++; $display("FAIL basic_cout got %b want 0", cout); end
    @(negedge clk);
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
    done_cyc = 0;
  endtask

  task automatic test_carry;
    int cyc;
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(cyc);
    vectors += 3;
    if (cyc != 9) begin miscompares++; $display("FAIL carry1_latency got %0d want 9", cyc); end
    if (sum !== 8'h00) begin miscompares++; $display("FAIL carry1_sum got %h want 00", sum); end
    if (cout !== 1'b1) begin miscompares++; $display("FAIL carry1_cout got %b want 1", cout); end
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(cyc);
    vectors += 3;
    if (cyc != 9) begin miscompares++; $display("FAIL carry2_latency got %0d want 9", cyc); end
    if (sum !== 8'hFF) begin miscompares++; $display("FAIL carry2_sum got %h want ff", sum); end
    if (cout !== 1'b1) begin miscompares++; $display("FAIL carry2_cout got %b want 1", cout); end
  endtask

  task automatic test_ignore_start;
    int pulses, done_at;
    pulses = 0; done_at = -1;
    launch(8'h10, 8'h20, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      if (i == 4) begin start = 1'b0; a = 8'h77; b = 8'h66; cin = 1'b1; end
      if (done) begin pulses++; if (done_at < 0) done_at = i; end
    end
    cin = 1'b0;
    vectors += 4;
    if (pulses != 1) begin miscompares++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    if (done_at != 9) begin miscompares++; $display("FAIL ignore_latency got %0d want 9", done_at); end
    if (sum !== 8'h30) begin miscompares++; $display("FAIL ignore_sum got %h want 30", sum); end
    if (cout !== 1'b0) begin miscompares++; $display("FAIL ignore_cout got %b want 0", cout); end
  endtask

  task automatic test_reset_mid;
    int pulses, cyc;
    pulses = 0;
    launch(8'h80, 8'h80, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", done); end
    if (sum !== 8'h00) begin miscompares++; $display("FAIL midrst_sum got %h want 00", sum); end
    if (cout !== 1'b0) begin miscompares++; $display("FAIL midrst_cout got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL midrst_stray_done got %0d want 0", pulses); end
    launch(8'h01, 8'h02, 1'b0);
    wait_done(cyc);
    vectors += 3;
    if (cyc != 9) begin miscompares++; $display("FAIL midrst_next_latency got %0d want 9", cyc); end
    if (sum !== 8'h03) begin miscompares++; $display("FAIL midrst_next_sum got %h want 03", sum); end
    if (cout !== 1'b0) begin miscompares++; $display("FAIL midrst_next_cout got %b want 0", cout); end
  endtask

  task automatic test_back_to_back;
    int first, second;
    logic [W-1:0] sum1, sum2;
    first = -1; second = -1; sum1 = '0; sum2 = '0;
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) begin
          first = i; sum1 = sum;
          a = 8'h02; b = 8'h03;
        end else begin
          second = i; sum2 = sum;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    vectors += 3;
    if (second - first != 9 || first < 0 || second < 0) begin
      miscompares++; $display("FAIL b2b_spacing got %0d want 9", second - first);
    end
    if (sum1 !== 8'h02) begin miscompares++; $display("FAIL b2b_sum1 got %h want 02", sum1); end
    if (sum2 !== 8'h05) begin miscompares++; $display("FAIL b2b_sum2 got %h want 05", sum2); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_clear got %b want 0", done); end
  endtask

  task automatic test_full_add_cell;
    int total;
    for (int i = 0; i < 8; i++) begin
      fa_x = i[2]; fa_y = i[1]; fa_ci = i[0];
      total = int'(i[2]) + int'(i[1]) + int'(i[0]);
      #1;
      vectors += 2;
      if (fa_s !== total[0]) begin miscompares++; $display("FAIL fa_s in %0d got %b want %b", i, fa_s, total[0]); end
      if (fa_co !== total[1]) begin miscompares++; $display("FAIL fa_cout in %0d got %b want %b", i, fa_co, total[1]); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   expect_v;
    int           cyc;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      expect_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      launch(ra, rb, rc);
      wait_done(cyc);
      vectors++;
      if (cyc != 9 || {cout, sum} !== expect_v) begin
        miscompares++;
        $display("FAIL random a=%h b=%h cin=%b got %b_%h cyc %0d want %b_%h cyc 9",
                 ra, rb, rc, cout, sum, cyc, expect_v[W], expect_v[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_full_add_cell;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
